chip_7474_emu: RTL

Cycle-accurate emulator of a 74LS74 dual positive-edge D flip-flop with preset and clear, on the device side of the chip-checker pin interface. It samples the eight stimulus pins that a checker drives (1–4, 10–13) and drives the four response pins that a checker reads (5, 6, 8, 9). Deterministic fault injection lets the checker's fail path be exercised without a physical bad part. It sits in place of the socketed DUT on the checker bench.

---
 rtl/chip_7474_emu.sv | 139 +++++++++++++
 1 files changed

// File: rtl/chip_7474_emu.sv
// chip_7474_emu: emulates a 74LS74 dual positive-edge D flip-flop with
// preset/clear on the device side of the chip-checker pin interface.
// Latency: a pin change reaches Pin5/6/8/9 and Edge_Cnt SYNC_STAGES+1 Clk cycles later.
// Backpressure: none; the pins are sampled every cycle and outputs are always driven.
//
// Ports:
//   Clk, Reset            system clock, async active-low reset
//   Pin1..Pin4            FF1 stimulus: 1CLR_n, 1D, 1CLK, 1PRE_n
//   Pin13..Pin10          FF2 stimulus: 2CLR_n, 2D, 2CLK, 2PRE_n
//   Pin5/Pin6, Pin9/Pin8  Q/Q_n of FF1 and FF2
//   Fault_En, Fault_Sel   fault injection: 1 Pin5 stuck-at-0, 2 FF2 Q/Q_n swap,
//                         3 FF1 ignores clock edges
//   Edge_Cnt1/2           saturating counts of accepted clock edges per FF
module chip_7474_emu #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Pin1,
  input  logic             Pin2,
  input  logic             Pin3,
  input  logic             Pin4,
  input  logic             Pin13,
  input  logic             Pin12,
  input  logic             Pin11,
  input  logic             Pin10,
  output logic             Pin5,
  output logic             Pin6,
  output logic             Pin9,
  output logic             Pin8,
  input  logic             Fault_En,
  input  logic [1:0]       Fault_Sel,
  output logic [CNT_W-1:0] Edge_Cnt1,
  output logic [CNT_W-1:0] Edge_Cnt2
);

  // Bit layout of the pin vector:
  //   0 clr1, 1 d1, 2 clk1, 3 pre1, 4 clr2, 5 d2, 6 clk2, 7 pre2
  // CLR_n/PRE_n chains reset high so no async event appears at reset release.
  localparam logic [7:0] SYNC_RST = 8'b1001_1001;

  logic [7:0] pin_vec;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] pin_s;

  assign pin_vec = {Pin10, Pin11, Pin12, Pin13, Pin4, Pin3, Pin2, Pin1};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= SYNC_RST;
      end
    end else begin
      sync_q[0] <= pin_vec;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign pin_s = sync_q[SYNC_STAGES-1];

  // Per-FF synchronized views, index 0 = FF1, index 1 = FF2.
  logic [1:0] clr_s, pre_s, clk_s, d_s;
  assign clr_s = {pin_s[4], pin_s[0]};
  assign d_s   = {pin_s[5], pin_s[1]};
  assign clk_s = {pin_s[6], pin_s[2]};
  assign pre_s = {pin_s[7], pin_s[3]};

  logic [1:0]       clk_d, d_d;
  logic [1:0]       s_q, q_q, qn_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       edge_ok;
  logic             ff1_clk_block;
  logic             pin5_stuck;
  logic             ff2_swap;

  assign ff1_clk_block = Fault_En && (Fault_Sel == 2'd3);
  assign pin5_stuck    = Fault_En && (Fault_Sel == 2'd1);
  assign ff2_swap      = Fault_En && (Fault_Sel == 2'd2);

  // An edge only counts when both async inputs are idle; in fault mode 3
  // FF1 edges are dropped entirely, so they are neither captured nor counted.
  assign edge_ok = (clk_s & ~clk_d) & pre_s & clr_s & {1'b1, ~ff1_clk_block};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_d    <= 2'b00;
      d_d      <= 2'b00;
      s_q      <= 2'b00;
      q_q      <= 2'b00;
      qn_q     <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      clk_d <= clk_s;
      // d_d lags the synchronized D by one cycle, so a D change landing with
      // the clock edge is not seen (setup-time behaviour).
      d_d   <= d_s;
      for (int f = 0; f < 2; f++) begin
        if (!pre_s[f] && !clr_s[f]) begin
          // Both async active: real part drives both outputs high.
          s_q[f]  <= 1'b0;
          q_q[f]  <= 1'b1;
          qn_q[f] <= 1'b1;
        end else if (!pre_s[f]) begin
          s_q[f]  <= 1'b1;
          q_q[f]  <= 1'b1;
          qn_q[f] <= 1'b0;
        end else if (!clr_s[f]) begin
          s_q[f]  <= 1'b0;
          q_q[f]  <= 1'b0;
          qn_q[f] <= 1'b1;
        end else if (edge_ok[f]) begin
          s_q[f]  <= d_d[f];
          q_q[f]  <= d_d[f];
          qn_q[f] <= ~d_d[f];
          if (cnt_q[f] != '1) begin
            cnt_q[f] <= cnt_q[f] + CNT_W'(1);
          end
        end else begin
          q_q[f]  <= s_q[f];
          qn_q[f] <= ~s_q[f];
        end
      end
    end
  end

  // Fault muxes sit after the registers so mode changes show up immediately.
  assign Pin5 = pin5_stuck ? 1'b0 : q_q[0];
  assign Pin6 = qn_q[0];
  assign Pin9 = ff2_swap ? qn_q[1] : q_q[1];
  assign Pin8 = ff2_swap ? q_q[1]  : qn_q[1];

  assign Edge_Cnt1 = cnt_q[0];
  assign Edge_Cnt2 = cnt_q[1];

endmodule
